clock_alarm_controller: RTL and testbench

CLOCK_ALARM_CONTROLLER -- requirements
Module: clock_alarm_controller

---
 rtl/clock_alarm_controller.sv | 191 +++++++++++++++++++
 tb/tb_clock_alarm_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_alarm_controller.sv
// -----------------------------------------------------------------------------
// clock_alarm_controller
//   Alarm controller for a 24-hour BCD clock. Holds a validated alarm time and
//   raises Ringing on the rising edge of a time match. The ring stops on Stop,
//   on an alarm reload, or after RING_SEC seconds. Snooze parks the alarm for
//   SNOOZE_SEC seconds and then rings again, up to MAX_SNOOZE times per event.
//
//   Optional feature macro: ALARM_SNOOZE_EN
//     defined   -> SNOOZE state, snooze counter and Snooze handling present
//     undefined -> Snooze ignored, Snoozing and Snooze_count tied to 0
//
// Ports
//   CLK           in   rising-edge clock
//   Reset_n       in   asynchronous active-low reset
//   Time_in[23:0] in   current time, BCD HH:MM:SS
//   Tick_1s       in   one-cycle pulse per elapsed second
//   Alarm_enable  in   level, 1 = alarm armed
//   Alarm_set     in   strobe, load Alarm_in when it is a valid time
//   Alarm_in[23:0]in   new alarm time, BCD HH:MM:SS
//   Snooze        in   strobe
//   Stop          in   strobe
//   Alarm_out     out  stored alarm time
//   Ringing       out  high while ringing
//   Snoozing      out  high while snoozing
//   Snooze_count  out  snoozes used in the current alarm event
//   Set_err       out  one-cycle pulse after a rejected Alarm_set
// -----------------------------------------------------------------------------
module clock_alarm_controller #(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic [23:0] Time_in,
  input  logic        Tick_1s,
  input  logic        Alarm_enable,
  input  logic        Alarm_set,
  input  logic [23:0] Alarm_in,
  input  logic        Snooze,
  input  logic        Stop,
  output logic [23:0] Alarm_out,
  output logic        Ringing,
  output logic        Snoozing,
  output logic [1:0]  Snooze_count,
  output logic        Set_err
);

  localparam int CNT_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] RING_LAST = CW'(RING_SEC - 1);

  typedef enum logic [1:0] {
    DISARMED,
    ARMED,
    RINGING
`ifdef ALARM_SNOOZE_EN
    , SNOOZE
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [23:0]   alarm_q, alarm_d;
  logic [23:0]   prev_time_q;
  logic [CW-1:0] ring_cnt_q, ring_cnt_d;
  logic          ringing_q, set_err_q, set_err_d;
  logic          set_ok, match;

  // Hours 00-23, minutes and seconds 00-59, every nibble a decimal digit.
  function automatic logic time_valid(input logic [23:0] t);
    return (t[23:20] <= 4'd2) && (t[19:16] <= 4'd9) &&
           !((t[23:20] == 4'd2) && (t[19:16] > 4'd3)) &&
           (t[15:12] <= 4'd5) && (t[11:8] <= 4'd9) &&
           (t[7:4]   <= 4'd5) && (t[3:0]  <= 4'd9);
  endfunction

  assign set_ok = Alarm_set && time_valid(Alarm_in);
  // Rising match only: a time that sits on the alarm value fires once.
  assign match  = (Time_in == alarm_q) && (prev_time_q != alarm_q);

`ifdef ALARM_SNOOZE_EN
  localparam logic [CW-1:0] SNZ_LAST = CW'(SNOOZE_SEC - 1);
  logic [CW-1:0] snz_cnt_q, snz_cnt_d;
  logic [1:0]    snooze_count_q, snooze_count_d;
  logic          snoozing_q;
`else
  logic [1:0]    unused_cfg;
  assign unused_cfg = {Snooze, 1'b0} ^ 2'(MAX_SNOOZE);
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d    = state_q;
    alarm_d    = set_ok ? Alarm_in : alarm_q;
    set_err_d  = Alarm_set && !time_valid(Alarm_in);
    ring_cnt_d = '0;
`ifdef ALARM_SNOOZE_EN
    snz_cnt_d      = '0;
    snooze_count_d = snooze_count_q;
`endif
    if (!Alarm_enable) begin
      state_d = DISARMED;
`ifdef ALARM_SNOOZE_EN
      snooze_count_d = '0;
`endif
    end else begin
      unique case (state_q)
        DISARMED: state_d = ARMED;
        ARMED: begin
          if (!set_ok && match) begin
            state_d = RINGING;
`ifdef ALARM_SNOOZE_EN
            snooze_count_d = '0;
`endif
          end
        end
        RINGING: begin
          if (set_ok || Stop) begin
            state_d = ARMED;
`ifdef ALARM_SNOOZE_EN
          end else if (Snooze && (snooze_count_q < 2'(MAX_SNOOZE))) begin
            state_d        = SNOOZE;
            snooze_count_d = snooze_count_q + 2'd1;
`endif
          end else if (Tick_1s) begin
            if (ring_cnt_q == RING_LAST) state_d = ARMED;
            else ring_cnt_d = ring_cnt_q + 1'b1;
          end else begin
            ring_cnt_d = ring_cnt_q;
          end
        end
`ifdef ALARM_SNOOZE_EN
        SNOOZE: begin
          if (set_ok || Stop) begin
            state_d = ARMED;
          end else if (Tick_1s) begin
            if (snz_cnt_q == SNZ_LAST) state_d = RINGING;
            else snz_cnt_d = snz_cnt_q + 1'b1;
          end else begin
            snz_cnt_d = snz_cnt_q;
          end
        end
`endif
        default: state_d = DISARMED;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= DISARMED;
      alarm_q     <= 24'h060000;
      prev_time_q <= 24'h000000;
      ring_cnt_q  <= '0;
      ringing_q   <= 1'b0;
      set_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      state_q     <= state_d;
      alarm_q     <= alarm_d;
      prev_time_q <= Time_in;
      ring_cnt_q  <= ring_cnt_d;
      ringing_q   <= (state_d == RINGING);
      set_err_q   <= set_err_d;
    end
  end

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      snz_cnt_q      <= '0;
      snooze_count_q <= 2'd0;
      snoozing_q     <= 1'b0;
    end else begin
      snz_cnt_q      <= snz_cnt_d;
      snooze_count_q <= snooze_count_d;
      snoozing_q     <= (state_d == SNOOZE);
    end
  end
  assign Snoozing     = snoozing_q;
  assign Snooze_count = snooze_count_q;
`else
  assign Snoozing     = 1'b0;
  assign Snooze_count = 2'd0;
`endif

  assign Alarm_out = alarm_q;
  assign Ringing   = ringing_q;
  assign Set_err   = set_err_q;

endmodule

// File: tb/tb_clock_alarm_controller.sv
// -----------------------------------------------------------------------------
// tb_clock_alarm_controller
//   Directed scenarios followed by randomized traffic, all checked every cycle
//   against a behavioural alarm model; literal checks pin the key scenarios.
// -----------------------------------------------------------------------------
module tb_clock_alarm_controller;
  localparam int RING_SEC   = 60;
  localparam int SNOOZE_SEC = 5;
  localparam int MAX_SNOOZE = 3;

  logic        CLK = 1'b0;
  logic        Reset_n = 1'b0;
  logic [23:0] Time_in = 24'h000000;
  logic        Tick_1s = 1'b0;
  logic        Alarm_enable = 1'b0;
  logic        Alarm_set = 1'b0;
  logic [23:0] Alarm_in = 24'h000000;
  logic        Snooze = 1'b0;
  logic        Stop = 1'b0;
  logic [23:0] Alarm_out;
  logic        Ringing, Snoozing, Set_err;
  logic [1:0]  Snooze_count;

  int n_tests = 0;
  int n_fail  = 0;

  clock_alarm_controller #(
    .RING_SEC(RING_SEC), .SNOOZE_SEC(SNOOZE_SEC), .MAX_SNOOZE(MAX_SNOOZE)
  ) dut (
    .CLK(CLK), .Reset_n(Reset_n), .Time_in(Time_in), .Tick_1s(Tick_1s),
    .Alarm_enable(Alarm_enable), .Alarm_set(Alarm_set), .Alarm_in(Alarm_in),
    .Snooze(Snooze), .Stop(Stop), .Alarm_out(Alarm_out), .Ringing(Ringing),
    .Snoozing(Snoozing), .Snooze_count(Snooze_count), .Set_err(Set_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Decimal view of a BCD time: legal when each field is in its clock range.
  function automatic bit time_ok(input logic [23:0] t);
    int d[6];
    for (int i = 0; i < 6; i++) begin
      d[i] = int'(t[i*4 +: 4]);
      if (d[i] > 9) return 1'b0;
    end
    return (d[5]*10 + d[4] < 24) && (d[3]*10 + d[2] < 60) && (d[1]*10 + d[0] < 60);
  endfunction

  // ---------------- behavioural model ----------------
  logic [23:0] m_alarm, m_prev;
  bit          m_on, m_ring, m_snz, m_set_err;
  int          m_secs, m_count;

  always @(posedge CLK or negedge Reset_n) begin : model
    bit ok, hit, on, ring, snz;
    int secs, cnt;
    if (!Reset_n) begin
      m_alarm <= 24'h060000; m_prev <= 24'h000000; m_on <= 1'b0;
      m_ring <= 1'b0; m_snz <= 1'b0; m_set_err <= 1'b0;
      m_secs <= 0; m_count <= 0;
    end else begin
      ok   = time_ok(Alarm_in);
      hit  = (Time_in == m_alarm) && (m_prev != m_alarm);
      on   = m_on; ring = m_ring; snz = m_snz; secs = m_secs; cnt = m_count;
      if (!Alarm_enable) begin
        on = 0; ring = 0; snz = 0; secs = 0; cnt = 0;
      end else if (!on) begin
        on = 1;
      end else if (Alarm_set && ok) begin
        ring = 0; snz = 0; secs = 0;
      end else if (ring) begin
        if (Stop) begin
          ring = 0; secs = 0;
`ifdef ALARM_SNOOZE_EN
        end else if (Snooze && cnt < MAX_SNOOZE) begin
          ring = 0; snz = 1; cnt = cnt + 1; secs = 0;
`endif
        end else if (Tick_1s) begin
          secs = secs + 1;
          if (secs == RING_SEC) begin ring = 0; secs = 0; end
        end
      end else if (snz) begin
        if (Stop) begin
          snz = 0; secs = 0;
        end else if (Tick_1s) begin
          secs = secs + 1;
          if (secs == SNOOZE_SEC) begin snz = 0; ring = 1; secs = 0; end
        end
      end else if (hit) begin
        ring = 1; secs = 0; cnt = 0;
      end
      m_alarm   <= (Alarm_set && ok) ? Alarm_in : m_alarm;
      m_set_err <= Alarm_set && !ok;
      m_prev    <= Time_in;
      m_on <= on; m_ring <= ring; m_snz <= snz; m_secs <= secs; m_count <= cnt;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge CLK) begin
    if (Reset_n) begin
      check("alarm_out", 32'(Alarm_out), 32'(m_alarm));
      check("ringing", 32'(Ringing), 32'(m_ring));
      check("snoozing", 32'(Snoozing), 32'(m_snz));
      check("snooze_count", 32'(Snooze_count), 32'(m_count));
      check("set_err", 32'(Set_err), 32'(m_set_err));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge CLK);
    #1;
    Alarm_set = 1'b0; Snooze = 1'b0; Stop = 1'b0; Tick_1s = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      Tick_1s = 1'b1;
      cyc();
    end
  endtask

  task automatic ring_start();
    Time_in = 24'h062959; cyc();
    Time_in = 24'h063000; cyc();
  endtask

  logic [23:0] times [4] = '{24'h063000, 24'h070000, 24'h235959, 24'h000000};

  initial begin
    #12 Reset_n = 1'b1;
    check("rst_alarm_out", 32'(Alarm_out), 32'h060000);
    check("rst_ringing", 32'(Ringing), 32'd0);
    check("rst_snoozing", 32'(Snoozing), 32'd0);
    check("rst_count", 32'(Snooze_count), 32'd0);
    check("rst_set_err", 32'(Set_err), 32'd0);

    Alarm_enable = 1'b1; cyc();

    // Invalid load: rejected with a one-cycle error pulse.
    Alarm_set = 1'b1; Alarm_in = 24'h246000; cyc();
    check("bad_set_err", 32'(Set_err), 32'd1);
    check("bad_set_keep", 32'(Alarm_out), 32'h060000);
    cyc();
    check("bad_set_pulse", 32'(Set_err), 32'd0);

    Alarm_set = 1'b1; Alarm_in = 24'h063000; cyc();
    check("good_set", 32'(Alarm_out), 32'h063000);

    // Rising match rings one cycle later; auto-stop after RING_SEC ticks.
    Time_in = 24'h062959; cyc();
    check("pre_match", 32'(Ringing), 32'd0);
    Time_in = 24'h063000; cyc();
    check("match_ring", 32'(Ringing), 32'd1);
    ticks(RING_SEC - 1);
    check("ring_59", 32'(Ringing), 32'd1);
    ticks(1);
    check("ring_60", 32'(Ringing), 32'd0);
    repeat (3) cyc();
    check("held_no_rering", 32'(Ringing), 32'd0);

`ifdef ALARM_SNOOZE_EN
    ring_start();
    for (int k = 1; k <= 3; k++) begin
      Snooze = 1'b1; cyc();
      check("snz_enter", 32'(Snoozing), 32'd1);
      check("snz_count", 32'(Snooze_count), 32'(k));
      ticks(SNOOZE_SEC - 1);
      check("snz_wait", 32'(Ringing), 32'd0);
      ticks(1);
      check("snz_rering", 32'(Ringing), 32'd1);
    end
    Snooze = 1'b1; cyc();
    check("snz4_ignored", 32'(Ringing), 32'd1);
    check("snz4_count", 32'(Snooze_count), 32'd3);
    Stop = 1'b1; cyc();
    check("stop_ring", 32'(Ringing), 32'd0);
    ring_start();
    check("count_cleared", 32'(Snooze_count), 32'd0);
    Snooze = 1'b1; cyc();
    ticks(SNOOZE_SEC);
    Stop = 1'b1; Snooze = 1'b1; cyc();
    check("stop_snz_ring", 32'(Ringing), 32'd0);
    check("stop_snz_snz", 32'(Snoozing), 32'd0);
    check("stop_snz_cnt", 32'(Snooze_count), 32'd1);
    ring_start();
    Snooze = 1'b1; cyc();
    check("snz_before_dis", 32'(Snoozing), 32'd1);
    Alarm_enable = 1'b0; cyc();
    check("dis_snoozing", 32'(Snoozing), 32'd0);
    check("dis_count", 32'(Snooze_count), 32'd0);
    Alarm_enable = 1'b1; cyc();
`else
    ring_start();
    Snooze = 1'b1; cyc();
    check("nosnz_ring", 32'(Ringing), 32'd1);
    check("nosnz_snoozing", 32'(Snoozing), 32'd0);
    Stop = 1'b1; cyc();
    check("nosnz_stop", 32'(Ringing), 32'd0);
`endif

    // Asynchronous reset between edges while ringing.
    ring_start();
    check("pre_reset_ring", 32'(Ringing), 32'd1);
    #1 Reset_n = 1'b0;
    #1;
    check("async_ring", 32'(Ringing), 32'd0);
    check("async_alarm", 32'(Alarm_out), 32'h060000);
    check("async_snz", 32'(Snoozing), 32'd0);
    #1 Reset_n = 1'b1;
    cyc();

    // Randomized traffic against the model.
    repeat (6000) begin
      Alarm_enable = ($urandom_range(0, 199) != 0);
      Tick_1s      = 1'($urandom_range(0, 1));
      Stop         = ($urandom_range(0, 149) == 0);
      Snooze       = ($urandom_range(0, 19) == 0);
      Alarm_set    = ($urandom_range(0, 99) == 0);
      Alarm_in     = ($urandom_range(0, 1) == 0) ? times[$urandom_range(0, 3)]
                                                 : 24'($urandom());
      Time_in      = times[$urandom_range(0, 3)];
      @(posedge CLK);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
